univ_shift_reg_burst: RTL and testbench



---
 rtl/univ_shift_reg_burst.sv | 139 +++++++++++++
 tb/tb_univ_shift_reg_burst.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_burst.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg_burst
// Brief    : Universal shift register with single-step and counted-burst modes,
//            busy/done handshake and serial outputs at both ends.
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg_burst #(
    parameter int                 WIDTH     = 8,
    parameter int                 AMT_W     = $clog2(WIDTH) + 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             c,
    input  logic             nrst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] c_op_hold = 3'b000;
    localparam logic [2:0] c_op_shl  = 3'b001;
    localparam logic [2:0] c_op_shr  = 3'b010;
    localparam logic [2:0] c_op_load = 3'b011;
    localparam logic [2:0] c_op_rol  = 3'b100;
    localparam logic [2:0] c_op_ror  = 3'b101;
    localparam logic [2:0] c_op_asr  = 3'b110;
    localparam logic [2:0] c_op_clr  = 3'b111;

    localparam logic [AMT_W-1:0] c_amt_zero = '0;
    localparam logic [AMT_W-1:0] c_amt_one  = AMT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [2:0]       r_op;
    logic [AMT_W-1:0] r_remain;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_step_op;
    logic [WIDTH-1:0] w_next;
    logic             w_is_burst_op;

    // While running, the latched op drives the datapath; the live op is ignored.
    assign w_step_op = (r_state == S_RUN) ? r_op : op;

    always_comb begin
        w_next = r_q;
        case (w_step_op)
            c_op_hold: w_next = r_q;
            c_op_shl:  w_next = {r_q[WIDTH-2:0], si};
            c_op_shr:  w_next = {si, r_q[WIDTH-1:1]};
            c_op_load: w_next = d;
            c_op_rol:  w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            c_op_ror:  w_next = {r_q[0], r_q[WIDTH-1:1]};
            c_op_asr:  w_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            c_op_clr:  w_next = '0;
            default:   w_next = r_q;
        endcase
    end

    always_comb begin
        w_is_burst_op = 1'b0;
        case (op)
            c_op_shl, c_op_shr, c_op_rol, c_op_ror, c_op_asr: w_is_burst_op = 1'b1;
            default:                                          w_is_burst_op = 1'b0;
        endcase
    end

    always_ff @(posedge c) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_q      <= RESET_VAL;
            r_op     <= c_op_hold;
            r_remain <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!w_is_burst_op) begin
                            r_q    <= w_next;
                            r_done <= 1'b1;
                        end else if (amt == c_amt_zero) begin
                            r_done <= 1'b1;
                        end else begin
                            // First step happens on the accepting edge itself.
                            r_q <= w_next;
                            if (amt == c_amt_one) begin
                                r_done <= 1'b1;
                            end else begin
                                r_op     <= op;
                                r_remain <= amt - c_amt_one;
                                r_state  <= S_RUN;
                                r_busy   <= 1'b1;
                            end
                        end
                    end else begin
                        r_q <= w_next;
                    end
                end
                S_RUN: begin
                    r_q      <= w_next;
                    r_remain <= r_remain - c_amt_one;
                    if (r_remain == c_amt_one) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q      = r_q;
    assign so_msb = r_q[WIDTH-1];
    assign so_lsb = r_q[0];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg_burst
// Brief    : Directed self-checking bench for univ_shift_reg_burst (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg_burst;

    localparam int c_width = 8;
    localparam int c_amt_w = 4;

    localparam logic [2:0] c_hold = 3'b000;
    localparam logic [2:0] c_shl  = 3'b001;
    localparam logic [2:0] c_shr  = 3'b010;
    localparam logic [2:0] c_load = 3'b011;
    localparam logic [2:0] c_rol  = 3'b100;
    localparam logic [2:0] c_ror  = 3'b101;
    localparam logic [2:0] c_asr  = 3'b110;
    localparam logic [2:0] c_clr  = 3'b111;

    logic               c;
    logic               nrst;
    logic [2:0]         op;
    logic [c_width-1:0] d;
    logic               si;
    logic               start;
    logic [c_amt_w-1:0] amt;
    logic [c_width-1:0] q;
    logic               so_msb;
    logic               so_lsb;
    logic               busy;
    logic               done;

    int n_compared;
    int n_mismatched;

    univ_shift_reg_burst #(
        .WIDTH     (c_width),
        .AMT_W     (c_amt_w),
        .RESET_VAL (8'h00)
    ) dut (
        .c      (c),
        .nrst   (nrst),
        .op     (op),
        .d      (d),
        .si     (si),
        .start  (start),
        .amt    (amt),
        .q      (q),
        .so_msb (so_msb),
        .so_lsb (so_lsb),
        .busy   (busy),
        .done   (done)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        nrst  = 1'b0;
        op    = c_hold;
        d     = 8'h00;
        si    = 1'b0;
        start = 1'b0;
        amt   = '0;
        tick();
        check_state("init_reset", 8'h00, 1'b0, 1'b0);

        // Reset dominates start/op
        nrst = 1'b1; op = c_load; d = 8'hA5;
        tick();
        check("preload_a5", 32'(q), 32'hA5);
        nrst = 1'b0; start = 1'b1; op = c_load; d = 8'hFF; amt = 4'd3;
        tick();
        check_state("reset_with_start", 8'h00, 1'b0, 1'b0);
        nrst = 1'b1; start = 1'b0; op = c_hold;
        tick();
        check_state("after_reset_hold", 8'h00, 1'b0, 1'b0);

        // Single-step ops
        op = c_load; d = 8'h96;
        tick();
        check_state("ss_load_96", 8'h96, 1'b0, 1'b0);
        check("so_msb_96", 32'(so_msb), 32'd1);
        check("so_lsb_96", 32'(so_lsb), 32'd0);
        op = c_shl; si = 1'b1;
        tick();
        check_state("ss_shl", 8'h2D, 1'b0, 1'b0);
        check("so_lsb_2d", 32'(so_lsb), 32'd1);
        op = c_shr; si = 1'b0;
        tick();
        check_state("ss_shr", 8'h16, 1'b0, 1'b0);
        op = c_load; d = 8'h96;
        tick();
        op = c_asr;
        tick();
        check_state("ss_asr", 8'hCB, 1'b0, 1'b0);
        op = c_ror;
        tick();
        check_state("ss_ror", 8'hE5, 1'b0, 1'b0);
        op = c_rol;
        tick();
        check_state("ss_rol", 8'hCB, 1'b0, 1'b0);
        op = c_clr;
        tick();
        check_state("ss_clr", 8'h00, 1'b0, 1'b0);

        // Burst ROL amt=3 on 0x81, LOAD driven while busy
        op = c_load; d = 8'h81;
        tick();
        start = 1'b1; op = c_rol; amt = 4'd3;
        tick();
        check_state("rol3_e1", 8'h03, 1'b1, 1'b0);
        start = 1'b0; op = c_load; d = 8'hFF;
        tick();
        check_state("rol3_e2", 8'h06, 1'b1, 1'b0);
        tick();
        check_state("rol3_e3", 8'h0C, 1'b0, 1'b1);
        op = c_hold;
        tick();
        check_state("rol3_after", 8'h0C, 1'b0, 1'b0);

        // ROR amt=8 on 0x3C returns the original value
        op = c_load; d = 8'h3C;
        tick();
        start = 1'b1; op = c_ror; amt = 4'd8;
        tick();
        start = 1'b0; op = c_hold;
        for (int i = 2; i <= 7; i++) tick();
        check_state("ror8_e7", 8'h3C >> 7 | 8'h3C << 1, 1'b1, 1'b0);
        tick();
        check_state("ror8_e8", 8'h3C, 1'b0, 1'b1);
        tick();

        // ROR amt=9 behaves as a single rotate
        start = 1'b1; op = c_ror; amt = 4'd9;
        tick();
        start = 1'b0; op = c_hold;
        for (int i = 2; i <= 9; i++) tick();
        check_state("ror9_done", 8'h1E, 1'b0, 1'b1);
        tick();

        // amt=0: no step, done pulse, busy never high
        start = 1'b1; op = c_ror; amt = 4'd0;
        tick();
        check_state("amt0", 8'h1E, 1'b0, 1'b1);
        start = 1'b0; op = c_hold;
        tick();
        check_state("amt0_after", 8'h1E, 1'b0, 1'b0);

        // Non-burst op with start: once, amt ignored
        start = 1'b1; op = c_load; d = 8'h5A; amt = 4'd3;
        tick();
        check_state("start_load", 8'h5A, 1'b0, 1'b1);
        start = 1'b0; op = c_hold;
        tick();
        check_state("start_load_after", 8'h5A, 1'b0, 1'b0);

        // ASR beyond WIDTH saturates to the sign
        op = c_load; d = 8'h80;
        tick();
        start = 1'b1; op = c_asr; amt = 4'd10;
        tick();
        start = 1'b0; op = c_hold;
        for (int i = 2; i <= 10; i++) tick();
        check_state("asr10", 8'hFF, 1'b0, 1'b1);
        tick();

        // Reset mid-burst aborts with no done
        op = c_clr;
        tick();
        start = 1'b1; op = c_shr; amt = 4'd5; si = 1'b1;
        tick();
        check_state("shr5_e1", 8'h80, 1'b1, 1'b0);
        start = 1'b0; op = c_hold;
        tick();
        check_state("shr5_e2", 8'hC0, 1'b1, 1'b0);
        nrst = 1'b0;
        tick();
        check_state("mid_reset", 8'h00, 1'b0, 1'b0);
        nrst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_done_after_abort", 32'(done), 32'd0);
        end
        check("q_after_abort", 32'(q), 32'h00);

        // Back-to-back bursts
        start = 1'b1; op = c_shl; amt = 4'd2; si = 1'b1;
        tick();
        check_state("b2b_e1", 8'h01, 1'b1, 1'b0);
        start = 1'b0; op = c_hold;
        tick();
        check_state("b2b_e2", 8'h03, 1'b0, 1'b1);
        start = 1'b1; op = c_rol; amt = 4'd1;
        tick();
        check_state("b2b_second", 8'h06, 1'b0, 1'b1);
        start = 1'b0; op = c_hold;
        tick();
        check_state("b2b_after", 8'h06, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
